// File: rtl/core_sequencer_if.sv
// Sequencer-side bundle between the dispatcher/datapath and core_sequencer.
// slave = the sequencer itself, master = the environment driving it.
interface core_sequencer_if #(
  parameter int THREADS_PER_BLOCK     = 4,
  parameter int PROGRAM_MEM_ADDR_BITS = 8
);
  localparam int T       = THREADS_PER_BLOCK;
  localparam int PCB     = PROGRAM_MEM_ADDR_BITS;
  localparam int TC_BITS = $clog2(T) + 1;

  logic               start;
  logic [TC_BITS-1:0] thread_count;
  logic               fetch_ready;
  logic               decoded_ret;
  logic [T-1:0]       lsu_busy;
  logic [T*PCB-1:0]   next_pc;
  logic [2:0]         core_state;
  logic [PCB-1:0]     current_pc;
  logic               fetch_valid;
  logic [T-1:0]       thread_enable;
  logic               done;
  logic               divergence_err;

  // Fetch handshake: fetch_valid is high for every FETCH cycle; the
  // instruction is accepted in a cycle where fetch_valid && fetch_ready,
  // and only then does the sequencer leave FETCH.
  modport master (
    output start, thread_count, fetch_ready, decoded_ret, lsu_busy, next_pc,
    input  core_state, current_pc, fetch_valid, thread_enable, done, divergence_err
  );

  modport slave (
    input  start, thread_count, fetch_ready, decoded_ret, lsu_busy, next_pc,
    output core_state, current_pc, fetch_valid, thread_enable, done, divergence_err
  );
endinterface

// File: rtl/core_sequencer.sv
// Per-core control FSM stepping one instruction at a time from FETCH to UPDATE.
// Optional macro CORE_SEQ_DIVERGENCE_CHECK_EN traps enabled threads whose next PC differs from thread 0.
module core_sequencer #(
  parameter int THREADS_PER_BLOCK     = 4,
  parameter int PROGRAM_MEM_ADDR_BITS = 8
) (
  input logic          clk,
  input logic          reset,
  core_sequencer_if.slave bus
);
  localparam int T       = THREADS_PER_BLOCK;
  localparam int PCB     = PROGRAM_MEM_ADDR_BITS;
  localparam int TC_BITS = $clog2(T) + 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_DECODE  = 3'd2,
    S_REQUEST = 3'd3,
    S_WAIT    = 3'd4,
    S_EXECUTE = 3'd5,
    S_UPDATE  = 3'd6,
    S_DONE    = 3'd7
  } state_t;

  state_t         state_q, state_d;
  logic [PCB-1:0] pc_q, pc_d;
  logic           done_q, done_d;
  logic           err_q, err_d;
  logic [T-1:0]   en_mask, en_q;
  logic [PCB-1:0] pc_lane0;
  logic           lsu_stall;
  logic           diverged;

  // A thread_count above T enables every lane, so no explicit clamp is needed.
  always_comb begin
    en_mask = '0;
    for (int i = 0; i < T; i++) begin
      en_mask[i] = (bus.thread_count > TC_BITS'(i));
    end
  end

  assign pc_lane0  = bus.next_pc[PCB-1:0];
  assign lsu_stall = |(bus.lsu_busy & en_mask);

`ifdef CORE_SEQ_DIVERGENCE_CHECK_EN
  always_comb begin
    diverged = 1'b0;
    for (int i = 1; i < T; i++) begin
      if (en_mask[i] && (bus.next_pc[i*PCB +: PCB] != pc_lane0)) begin
        diverged = 1'b1;
      end
    end
  end
`else
  logic unused_lanes;
  assign unused_lanes = ^bus.next_pc;
  assign diverged     = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      en_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      done_q  <= done_d;
      err_q   <= err_d;
      en_q    <= en_mask;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    done_d  = done_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          if (bus.thread_count == '0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_FETCH;
          end
        end
      end
      S_FETCH:   if (bus.fetch_ready) state_d = S_DECODE;
      S_DECODE:  state_d = S_REQUEST;
      S_REQUEST: state_d = S_WAIT;
      S_WAIT:    if (!lsu_stall) state_d = S_EXECUTE;
      S_EXECUTE: state_d = S_UPDATE;
      S_UPDATE: begin
        // PC is frozen on RET and on a divergence trap so it points at the culprit.
        if (bus.decoded_ret) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else if (diverged) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end else begin
          pc_d    = pc_lane0;
          state_d = S_FETCH;
        end
      end
      S_DONE:  state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.core_state     = state_q;
  assign bus.current_pc     = pc_q;
  assign bus.fetch_valid    = (state_q == S_FETCH);
  assign bus.thread_enable  = en_q;
  assign bus.done           = done_q;
  assign bus.divergence_err = err_q;
endmodule

// File: tb/tb_core_sequencer.sv
// Self-checking bench for core_sequencer: directed scenarios plus randomized
// blocks scored against a cycle-plan reference model.
module tb_core_sequencer;
  localparam int T   = 4;
  localparam int PCB = 8;
  localparam int TCB = 3;
  localparam int W   = 17;

  typedef struct packed {
    logic             start;
    logic             fr;
    logic             ret;
    logic [T-1:0]     busy;
    logic [T*PCB-1:0] npc;
  } stim_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  core_sequencer_if #(.THREADS_PER_BLOCK(T), .PROGRAM_MEM_ADDR_BITS(PCB)) bus ();
  core_sequencer #(.THREADS_PER_BLOCK(T), .PROGRAM_MEM_ADDR_BITS(PCB)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  logic [W-1:0] exp_q[$];
  stim_t        stim_q[$];

  logic [PCB-1:0] pc_m;
  logic           done_m, err_m;
  logic [T-1:0]   te_m;

  function automatic logic [T*PCB-1:0] pack_pcs(input int p0, input int p1, input int p2, input int p3);
    logic [PCB-1:0] a, b, c, d;
    a = PCB'(p0); b = PCB'(p1); c = PCB'(p2); d = PCB'(p3);
    return {d, c, b, a};
  endfunction

  // ---------------- clock/reset and driver tasks ----------------
  task automatic do_reset();
    @(negedge clk);
    reset            = 1'b1;
    bus.start        = 1'b1;
    bus.fetch_ready  = 1'($urandom);
    bus.decoded_ret  = 1'($urandom);
    bus.lsu_busy     = T'($urandom);
    bus.next_pc      = $urandom;
    bus.thread_count = TCB'($urandom_range(0, 7));
    repeat (2) @(negedge clk);
    reset            = 1'b0;
    bus.start        = 1'b0;
    bus.decoded_ret  = 1'b0;
    bus.lsu_busy     = '0;
  endtask

  task automatic begin_block(input int count);
    do_reset();
    bus.thread_count = TCB'(count);
    bus.fetch_ready  = 1'b1;
    bus.start        = 1'b1;
    @(negedge clk);
  endtask

  // ---------------- directed scenarios ----------------
  task automatic test_reset();
    @(negedge clk);
    reset           = 1'b1;
    bus.start       = 1'b1;
    bus.fetch_ready = 1'b1;
    bus.decoded_ret = 1'b1;
    bus.lsu_busy    = '1;
    bus.next_pc     = $urandom;
    bus.thread_count = 3'd4;
    repeat (3) @(negedge clk);
    n_cmp++; if (bus.core_state !== 3'd0) begin n_err++; $display("FAIL reset_state: got %0d expected 0", bus.core_state); end
    n_cmp++; if (bus.current_pc !== 8'd0) begin n_err++; $display("FAIL reset_pc: got %0d expected 0", bus.current_pc); end
    n_cmp++; if (bus.fetch_valid !== 1'b0) begin n_err++; $display("FAIL reset_fetch_valid: got %b expected 0", bus.fetch_valid); end
    n_cmp++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b expected 0", bus.done); end
    n_cmp++; if (bus.divergence_err !== 1'b0) begin n_err++; $display("FAIL reset_err: got %b expected 0", bus.divergence_err); end
    reset     = 1'b0;
    bus.start = 1'b0;
  endtask

  task automatic test_basic_sequence();
    logic [2:0] exp_seq [7];
    exp_seq = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd1};
    begin_block(4);
    bus.next_pc = pack_pcs(1, 1, 1, 1);
    for (int i = 0; i < 7; i++) begin
      if (i > 0) @(negedge clk);
      n_cmp++; if (bus.core_state !== exp_seq[i]) begin n_err++; $display("FAIL basic_state[%0d]: got %0d expected %0d", i, bus.core_state, exp_seq[i]); end
      n_cmp++; if (bus.fetch_valid !== (exp_seq[i] == 3'd1)) begin n_err++; $display("FAIL basic_fetch_valid[%0d]: got %b", i, bus.fetch_valid); end
    end
    n_cmp++; if (bus.current_pc !== 8'd1) begin n_err++; $display("FAIL basic_pc: got %0d expected 1", bus.current_pc); end
    n_cmp++; if (bus.thread_enable !== 4'hF) begin n_err++; $display("FAIL basic_thread_enable: got %h expected f", bus.thread_enable); end
  endtask

  task automatic test_fetch_stall();
    begin_block(4);
    bus.fetch_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp++; if (bus.core_state !== 3'd1) begin n_err++; $display("FAIL stall_state[%0d]: got %0d expected 1", i, bus.core_state); end
      n_cmp++; if (bus.fetch_valid !== 1'b1) begin n_err++; $display("FAIL stall_fetch_valid[%0d]: got %b expected 1", i, bus.fetch_valid); end
    end
    bus.fetch_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus.core_state !== 3'd2) begin n_err++; $display("FAIL stall_release: got %0d expected 2", bus.core_state); end
  endtask

  task automatic test_wait_masking();
    begin_block(2);
    bus.next_pc  = pack_pcs(3, 3, 8, 9);
    bus.lsu_busy = 4'b1000;
    repeat (3) @(negedge clk);
    n_cmp++; if (bus.core_state !== 3'd4) begin n_err++; $display("FAIL mask_wait: got %0d expected 4", bus.core_state); end
    n_cmp++; if (bus.thread_enable !== 4'b0011) begin n_err++; $display("FAIL mask_thread_enable: got %b expected 0011", bus.thread_enable); end
    @(negedge clk);
    n_cmp++; if (bus.core_state !== 3'd5) begin n_err++; $display("FAIL mask_no_extend: got %0d expected 5", bus.core_state); end
    repeat (5) @(negedge clk);
    n_cmp++; if (bus.core_state !== 3'd4) begin n_err++; $display("FAIL mask_wait2: got %0d expected 4", bus.core_state); end
    bus.lsu_busy = 4'b0010;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++; if (bus.core_state !== 3'd4) begin n_err++; $display("FAIL mask_extend[%0d]: got %0d expected 4", i, bus.core_state); end
    end
    bus.lsu_busy = 4'b0000;
    @(negedge clk);
    n_cmp++; if (bus.core_state !== 3'd5) begin n_err++; $display("FAIL mask_release: got %0d expected 5", bus.core_state); end
  endtask

  task automatic test_ret_done();
    begin_block(4);
    bus.next_pc = pack_pcs(7, 7, 7, 7);
    repeat (6) @(negedge clk);
    n_cmp++; if (bus.current_pc !== 8'd7) begin n_err++; $display("FAIL ret_pc_before: got %0d expected 7", bus.current_pc); end
    bus.decoded_ret = 1'b1;
    repeat (5) @(negedge clk);
    n_cmp++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL ret_done_early: got %b expected 0", bus.done); end
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      n_cmp++; if (bus.core_state !== 3'd7) begin n_err++; $display("FAIL ret_state[%0d]: got %0d expected 7", i, bus.core_state); end
      n_cmp++; if (bus.done !== 1'b1) begin n_err++; $display("FAIL ret_done[%0d]: got %b expected 1", i, bus.done); end
      n_cmp++; if (bus.current_pc !== 8'd7) begin n_err++; $display("FAIL ret_pc[%0d]: got %0d expected 7", i, bus.current_pc); end
      bus.start   = ~bus.start;
      bus.next_pc = $urandom;
      @(negedge clk);
    end
    bus.decoded_ret = 1'b0;
  endtask

  task automatic test_zero_threads();
    do_reset();
    bus.thread_count = 3'd0;
    bus.start        = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus.core_state !== 3'd7) begin n_err++; $display("FAIL zero_state: got %0d expected 7", bus.core_state); end
    n_cmp++; if (bus.done !== 1'b1) begin n_err++; $display("FAIL zero_done: got %b expected 1", bus.done); end
    n_cmp++; if (bus.fetch_valid !== 1'b0) begin n_err++; $display("FAIL zero_fetch_valid: got %b expected 0", bus.fetch_valid); end
  endtask

  task automatic test_divergence();
    begin_block(4);
    bus.next_pc = pack_pcs(5, 5, 9, 5);
    repeat (6) @(negedge clk);
`ifdef CORE_SEQ_DIVERGENCE_CHECK_EN
    n_cmp++; if (bus.core_state !== 3'd7) begin n_err++; $display("FAIL div_state: got %0d expected 7", bus.core_state); end
    n_cmp++; if (bus.divergence_err !== 1'b1) begin n_err++; $display("FAIL div_err: got %b expected 1", bus.divergence_err); end
    n_cmp++; if (bus.done !== 1'b1) begin n_err++; $display("FAIL div_done: got %b expected 1", bus.done); end
    n_cmp++; if (bus.current_pc !== 8'd0) begin n_err++; $display("FAIL div_pc: got %0d expected 0", bus.current_pc); end
`else
    n_cmp++; if (bus.core_state !== 3'd1) begin n_err++; $display("FAIL div_state: got %0d expected 1", bus.core_state); end
    n_cmp++; if (bus.divergence_err !== 1'b0) begin n_err++; $display("FAIL div_err: got %b expected 0", bus.divergence_err); end
    n_cmp++; if (bus.current_pc !== 8'd5) begin n_err++; $display("FAIL div_pc: got %0d expected 5", bus.current_pc); end
`endif
    begin_block(2);
    bus.next_pc = pack_pcs(5, 5, 9, 5);
    repeat (6) @(negedge clk);
    n_cmp++; if (bus.core_state !== 3'd1) begin n_err++; $display("FAIL div2_state: got %0d expected 1", bus.core_state); end
    n_cmp++; if (bus.divergence_err !== 1'b0) begin n_err++; $display("FAIL div2_err: got %b expected 0", bus.divergence_err); end
    n_cmp++; if (bus.current_pc !== 8'd5) begin n_err++; $display("FAIL div2_pc: got %0d expected 5", bus.current_pc); end
  endtask

  task automatic test_reset_in_wait();
    int v;
    v = $urandom_range(1, 255);
    begin_block(4);
    bus.next_pc = pack_pcs(v, v, v, v);
    repeat (6) @(negedge clk);
    n_cmp++; if (bus.current_pc !== PCB'(v)) begin n_err++; $display("FAIL rstw_pc_before: got %0d expected %0d", bus.current_pc, v); end
    repeat (3) @(negedge clk);
    n_cmp++; if (bus.core_state !== 3'd4) begin n_err++; $display("FAIL rstw_in_wait: got %0d expected 4", bus.core_state); end
    reset = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus.core_state !== 3'd0) begin n_err++; $display("FAIL rstw_state: got %0d expected 0", bus.core_state); end
    n_cmp++; if (bus.current_pc !== 8'd0) begin n_err++; $display("FAIL rstw_pc: got %0d expected 0", bus.current_pc); end
    n_cmp++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL rstw_done: got %b expected 0", bus.done); end
    reset = 1'b0;
  endtask

  // ---------------- randomized blocks against the reference plan ----------------
  // Records what the core should show in one cycle and the inputs applied during it.
  task automatic plan(input logic [2:0] st, input logic start, input logic fr, input logic ret,
                      input logic [T-1:0] busy, input logic [T*PCB-1:0] npc);
    stim_t s;
    exp_q.push_back({err_m, done_m, te_m, pc_m, st});
    s.start = start; s.fr = fr; s.ret = ret; s.busy = busy; s.npc = npc;
    stim_q.push_back(s);
  endtask

  task automatic test_random();
    for (int blk = 0; blk < 24; blk++) begin
      int count, en_n, n_ins, stall, wcyc, idx;
      logic [T-1:0] en;
      logic [T*PCB-1:0] npc;
      logic [PCB-1:0] lane0;
      logic div;
      count = $urandom_range(0, 7);
      en_n  = (count > T) ? T : count;
      en    = '0;
      for (int i = 0; i < T; i++) en[i] = (i < en_n);
      pc_m = '0; done_m = 1'b0; err_m = 1'b0; te_m = '0;
      do_reset();
      bus.thread_count = TCB'(count);
      plan(3'd0, 1'b1, 1'($urandom), 1'($urandom), T'($urandom), $urandom);
      te_m = en;
      if (en_n == 0) begin
        done_m = 1'b1;
      end else begin
        n_ins = $urandom_range(1, 5);
        for (int k = 0; k < n_ins; k++) begin
          stall = $urandom_range(0, 2);
          wcyc  = $urandom_range(0, 3);
          lane0 = PCB'($urandom);
          npc   = '0;
          for (int i = 0; i < T; i++)
            npc[i*PCB +: PCB] = ($urandom_range(0, 3) == 0) ? PCB'($urandom) : lane0;
          npc[PCB-1:0] = lane0;
          for (int j = 0; j <= stall; j++)
            plan(3'd1, 1'($urandom), (j == stall), 1'($urandom), T'($urandom), $urandom);
          plan(3'd2, 1'($urandom), 1'($urandom), 1'($urandom), T'($urandom), $urandom);
          plan(3'd3, 1'($urandom), 1'($urandom), 1'($urandom), T'($urandom), $urandom);
          for (int j = 0; j <= wcyc; j++) begin
            idx = $urandom_range(0, en_n - 1);
            if (j < wcyc) plan(3'd4, 1'($urandom), 1'($urandom), 1'($urandom), T'($urandom) | T'(1 << idx), $urandom);
            else          plan(3'd4, 1'($urandom), 1'($urandom), 1'($urandom), T'($urandom) & ~en, $urandom);
          end
          plan(3'd5, 1'($urandom), 1'($urandom), 1'($urandom), T'($urandom), $urandom);
          plan(3'd6, 1'($urandom), 1'($urandom), (k == n_ins - 1), T'($urandom), npc);
          div = 1'b0;
          for (int i = 1; i < en_n; i++) if (npc[i*PCB +: PCB] != lane0) div = 1'b1;
          if (k == n_ins - 1) begin
            done_m = 1'b1;
            break;
          end
`ifdef CORE_SEQ_DIVERGENCE_CHECK_EN
          if (div) begin
            done_m = 1'b1;
            err_m  = 1'b1;
            break;
          end
`endif
          pc_m = lane0;
        end
      end
      for (int j = 0; j < 3; j++)
        plan(3'd7, 1'($urandom), 1'($urandom), 1'($urandom), T'($urandom), $urandom);

      while (exp_q.size() > 0) begin
        logic [W-1:0] e, got;
        stim_t s;
        e   = exp_q.pop_front();
        s   = stim_q.pop_front();
        got = {bus.divergence_err, bus.done, bus.thread_enable, bus.current_pc, bus.core_state};
        n_cmp++; if (got !== e) begin n_err++; $display("FAIL rand_blk%0d: got %h expected %h (err,done,en,pc,state)", blk, got, e); end
        n_cmp++; if (bus.fetch_valid !== (e[2:0] == 3'd1)) begin n_err++; $display("FAIL rand_fetch_valid_blk%0d: got %b expected %b", blk, bus.fetch_valid, (e[2:0] == 3'd1)); end
        bus.start       = s.start;
        bus.fetch_ready = s.fr;
        bus.decoded_ret = s.ret;
        bus.lsu_busy    = s.busy;
        bus.next_pc     = s.npc;
        @(negedge clk);
      end
    end
  endtask

  initial begin
    reset            = 1'b1;
    bus.start        = 1'b0;
    bus.thread_count = '0;
    bus.fetch_ready  = 1'b0;
    bus.decoded_ret  = 1'b0;
    bus.lsu_busy     = '0;
    bus.next_pc      = '0;
    test_reset();
    test_basic_sequence();
    test_fetch_stall();
    test_wait_masking();
    test_ret_done();
    test_zero_threads();
    test_divergence();
    test_reset_in_wait();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
